booth_algorithm: RTL and testbench

- Sequential radix-2 Booth multiplier.
- Multiplies two N-bit two's-complement operands into a 2N-bit two's-complement product, one Booth step per clock.
- Used as the mantissa multiplier of the floating-point multiplier datapath. With default N = MB+2 = 25, operands are {2'b01, mantissa}, so positive operands behave as unsigned.
- Operands are captured on a start handshake; the result is held until the next accepted start.

---
 rtl/booth_algorithm_pkg.sv | 9 +
 rtl/booth_algorithm.sv | 118 +++++++++++
 tb/tb_booth_algorithm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/booth_algorithm_pkg.sv
// Floating-point format constants shared by the FP multiplier datapath.
// The Booth mantissa multiplier takes its operand width from here.
package booth_algorithm_pkg;

    localparam int MB      = 23;       // stored mantissa bits
    localparam int EB      = 8;        // exponent bits
    localparam int BOOTH_N = MB + 2;   // {2'b01, mantissa} operand width

endpackage

// File: rtl/booth_algorithm.sv
// Sequential radix-2 Booth multiplier: N-bit signed x N-bit signed -> 2N-bit
// signed product, one Booth step per clock. The accumulator A carries one
// extra bit so that min x min is representable without overflow.
module booth_algorithm
    import booth_algorithm_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplier,
    input  logic [N-1:0]   multiplicand,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N:0]     m_q, m_d;
    logic [N:0]     a_q, a_d;
    logic [N-1:0]   q_q, q_d;
    logic           q1_q, q1_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] prod_q, prod_d;

    logic [N:0]     sum;
    logic [N:0]     a_step;
    logic [N-1:0]   q_step;
    logic           q1_step;

    // One Booth step: conditional add/subtract of M, then arithmetic right
    // shift of {A,Q,q_1} replicating the sign of the updated accumulator.
    always_comb begin
        sum = a_q;
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        {a_step, q_step} = {sum[N], sum, q_q[N-1:1]};
        q1_step          = q_q[0];
    end

    // Next-state, datapath loads and status outputs.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[N-1], multiplicand};
                    a_d     = '0;
                    q_d     = multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(N);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                a_d   = a_step;
                q_d   = q_step;
                q1_d  = q1_step;
                cnt_d = cnt_q - CW'(1);
                // Last step: capture the result so it is valid alongside done.
                if (cnt_q == CW'(1)) begin
                    prod_d  = {a_step[N-1:0], q_step};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_booth_algorithm.sv
// Self-checking bench for booth_algorithm (N=25): directed and random
// operands compared against signed integer multiplication.
module tb_booth_algorithm;

    localparam int N = 25;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplier;
    logic [N-1:0]   multiplicand;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] held;   // last product the DUT should be holding

    booth_algorithm #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p[2*N-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned at a negedge. Issues start, optionally injects an
    // ignored start 10 cycles in, and checks latency, busy time, product
    // hold during the run, result and the single-cycle done pulse.
    task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit inject);
        logic [2*N-1:0] exp;
        int cyc, busy_cnt;
        bit held_ok;
        exp          = ref_mul(a, b);
        start        = 1'b1;
        multiplier   = a;
        multiplicand = b;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        held_ok  = 1'b1;
        while (!done && cyc < 4 * N) begin
            if (busy) busy_cnt++;
            if (product !== held) held_ok = 1'b0;
            if (inject && cyc == 10) begin
                start        = 1'b1;
                multiplier   = $urandom;
                multiplicand = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(N + 1));
        chk({tag, "_busy"}, 64'(busy_cnt), 64'(N));
        chk({tag, "_hold"}, 64'(held_ok), 64'd1);
        chk({tag, "_prod"}, 64'(product), 64'(exp));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        held = exp;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_prod_held"}, 64'(product), 64'(exp));
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        bit saw_done;
        rst          = 1'b1;
        start        = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        held         = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_prod", 64'(product), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with spec-given constants.
        run_mul("mul3x5", 25'd3, 25'd5, 1'b0);
        chk("mul3x5_const", 64'(product), 64'd15);
        run_mul("neg3x5", 25'h1FFFFFD, 25'd5, 1'b0);
        chk("neg3x5_const", 64'(product), 64'h3FFFFFFFFFFF1);
        run_mul("one_one", 25'h0800000, 25'h0800000, 1'b0);
        chk("one_one_const", 64'(product), 64'h0400000000000);
        run_mul("max_mant", 25'h0FFFFFF, 25'h0FFFFFF, 1'b0);
        chk("max_mant_const", 64'(product), 64'h0FFFFFE000001);
        run_mul("min_min", 25'h1000000, 25'h1000000, 1'b0);
        chk("min_min_const", 64'(product), 64'h1000000000000);

        // Start pulse mid-run must be ignored.
        run_mul("inject", 25'd1234, 25'h1FFFF00, 1'b1);
        // Back-to-back: run_mul returns in the cycle after done, start again now.
        run_mul("b2b", 25'h0ABCDEF, 25'h1234567, 1'b0);

        // Start presented in the DONE cycle is ignored.
        start = 1'b1; multiplier = 25'd2; multiplicand = 25'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (N) @(negedge clk);
        start = 1'b1;   // done is high in this cycle
        @(negedge clk);
        start = 1'b0;
        held = ref_mul(25'd2, 25'd2);
        chk("done_start_ignored", 64'(busy), 64'd0);
        chk("done_start_prod", 64'(product), 64'd4);

        // Reset mid-run aborts without a done pulse.
        start = 1'b1; multiplier = 25'd100; multiplicand = 25'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_prod", 64'(product), 64'd0);
        saw_done = 1'b0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        held = '0;
        run_mul("after_rst", 25'd7, 25'd9, 1'b0);
        chk("after_rst_const", 64'(product), 64'd63);

        // Random operands, with occasional extreme values.
        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i % 7 == 3) ra = 25'h1000000;
            if (i % 5 == 4) rb = 25'h0FFFFFF;
            run_mul("rand", ra, rb, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
